// File: rtl/instr_exec_register.sv
// Instruction register: DEPTH entries of opcode/operands/result with an
// in-line ALU and an iterative restoring divider for DIV/MOD.
module instr_exec_register #(
   parameter int OP_WIDTH   = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int RES_WIDTH  = 2*OP_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] write_pointer,
   input  logic [3:0]            opcode,
   input  logic [OP_WIDTH-1:0]   operand_a,
   input  logic [OP_WIDTH-1:0]   operand_b,
   input  logic [ADDR_WIDTH-1:0] read_pointer,
   output logic                  busy,
   output logic                  load_rejected,
   output logic                  done,
   output logic                  rd_valid,
   output logic [3:0]            rd_opcode,
   output logic [OP_WIDTH-1:0]   rd_op_a,
   output logic [OP_WIDTH-1:0]   rd_op_b,
   output logic [RES_WIDTH-1:0]  rd_result,
   output logic [1:0]            rd_status
);

   localparam int CW = $clog2(OP_WIDTH) + 1;
   localparam int XW = RES_WIDTH - OP_WIDTH;

   typedef enum logic [1:0] {IDLE, DIVIDE, WRITEBACK} state_t;

   state_t state_q, state_d;

   logic [DEPTH-1:0]     valid_q;
   logic [3:0]           mem_op  [DEPTH];
   logic [OP_WIDTH-1:0]  mem_a   [DEPTH];
   logic [OP_WIDTH-1:0]  mem_b   [DEPTH];
   logic [RES_WIDTH-1:0] mem_res [DEPTH];
   logic [1:0]           mem_st  [DEPTH];

   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [3:0]            op_q;
   logic [OP_WIDTH-1:0]   a_q, b_q, d_q, q_q;
   logic [OP_WIDTH:0]     r_q;
   logic [CW-1:0]         cnt_q;
   logic                  neg_a_q, neg_b_q;

   logic is_div, accept, single, div_start, wr_en;
   logic signed [RES_WIDTH-1:0] ax, bx;
   logic [RES_WIDTH-1:0] alu_res, div_res, qz, rz, wr_res;
   logic [OP_WIDTH-1:0]  mag_a, mag_b, q_next;
   logic [OP_WIDTH:0]    shifted, r_next;
   logic                 ge, dz;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [3:0]           wr_op;
   logic [OP_WIDTH-1:0]  wr_a, wr_b;
   logic [1:0]           wr_st;

   assign busy      = (state_q != IDLE);
   assign is_div    = (opcode == 4'd6) || (opcode == 4'd7);
   assign accept    = load_en && !busy;
   assign single    = accept && !is_div;
   assign div_start = accept && is_div;

   assign ax = {{XW{operand_a[OP_WIDTH-1]}}, operand_a};
   assign bx = {{XW{operand_b[OP_WIDTH-1]}}, operand_b};

   always_comb begin
      alu_res = '0;
      unique case (opcode)
         4'd1:    alu_res = ax;
         4'd2:    alu_res = bx;
         4'd3:    alu_res = ax + bx;
         4'd4:    alu_res = ax - bx;
         4'd5:    alu_res = ax * bx;
         default: alu_res = '0;
      endcase
   end

   // Magnitudes fit in OP_WIDTH unsigned bits, including the MIN case
   assign mag_a = operand_a[OP_WIDTH-1] ? (~operand_a + OP_WIDTH'(1)) : operand_a;
   assign mag_b = operand_b[OP_WIDTH-1] ? (~operand_b + OP_WIDTH'(1)) : operand_b;

   assign shifted = {r_q[OP_WIDTH-1:0], q_q[OP_WIDTH-1]};
   assign ge      = (shifted >= {1'b0, d_q});
   assign r_next  = ge ? (shifted - {1'b0, d_q}) : shifted;
   assign q_next  = {q_q[OP_WIDTH-2:0], ge};

   assign dz = (b_q == '0);
   assign qz = {{XW{1'b0}}, q_q};
   assign rz = {{XW{1'b0}}, r_q[OP_WIDTH-1:0]};

   always_comb begin
      div_res = '0;
      if (dz)
         div_res = '0;
      else if (op_q == 4'd7)
         div_res = neg_a_q ? -rz : rz;
      else
         div_res = (neg_a_q ^ neg_b_q) ? -qz : qz;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (div_start) state_d = DIVIDE;
         DIVIDE:    if (cnt_q == CW'(OP_WIDTH-1)) state_d = WRITEBACK;
         WRITEBACK: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   assign wr_en  = single || (state_q == WRITEBACK);
   assign wr_ptr = single ? write_pointer : ptr_q;
   assign wr_op  = single ? opcode : op_q;
   assign wr_a   = single ? operand_a : a_q;
   assign wr_b   = single ? operand_b : b_q;
   assign wr_res = single ? alu_res : div_res;
   assign wr_st  = single ? {opcode[3], 1'b0} : {1'b0, dz};

   always_ff @(posedge clk) begin
      if (div_start) begin
         ptr_q   <= write_pointer;
         op_q    <= opcode;
         a_q     <= operand_a;
         b_q     <= operand_b;
         d_q     <= mag_b;
         q_q     <= mag_a;
         r_q     <= '0;
         cnt_q   <= '0;
         neg_a_q <= operand_a[OP_WIDTH-1];
         neg_b_q <= operand_b[OP_WIDTH-1];
      end else if (state_q == DIVIDE) begin
         q_q   <= q_next;
         r_q   <= r_next;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && wr_en) begin
         mem_op[wr_ptr]  <= wr_op;
         mem_a[wr_ptr]   <= wr_a;
         mem_b[wr_ptr]   <= wr_b;
         mem_res[wr_ptr] <= wr_res;
         mem_st[wr_ptr]  <= wr_st;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q       <= '0;
         done          <= 1'b0;
         load_rejected <= 1'b0;
         rd_valid      <= 1'b0;
         rd_opcode     <= '0;
         rd_op_a       <= '0;
         rd_op_b       <= '0;
         rd_result     <= '0;
         rd_status     <= '0;
      end else begin
         done          <= wr_en;
         load_rejected <= load_en && busy;
         if (wr_en)     valid_q[wr_ptr] <= 1'b1;
         if (div_start) valid_q[write_pointer] <= 1'b0;
         // Read sees pre-write contents on a same-edge collision
         rd_valid <= valid_q[read_pointer];
         if (valid_q[read_pointer]) begin
            rd_opcode <= mem_op[read_pointer];
            rd_op_a   <= mem_a[read_pointer];
            rd_op_b   <= mem_b[read_pointer];
            rd_result <= mem_res[read_pointer];
            rd_status <= mem_st[read_pointer];
         end else begin
            rd_opcode <= '0;
            rd_op_a   <= '0;
            rd_op_b   <= '0;
            rd_result <= '0;
            rd_status <= '0;
         end
      end
   end

endmodule
